// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder-tree input side.
//   packer_state_t : packer FSM states (FILL, STALL)
//   lane_cnt_w(n)  : width of a count that can hold 0..n
package adder_tree_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      STALL = 1'b1
   } packer_state_t;

   function automatic int lane_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pipeline_stage.sv
// Generic enable-gated register slice.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset (clears q)
//   en  : load d into q on the next rising edge
//   d   : next value
//   q   : registered value (or d directly when ENABLE = 0)
module pipeline_stage #(
   parameter int WIDTH  = 1,
   parameter int ENABLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (ENABLE != 0) begin : g_reg
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               q <= '0;
            end else if (en) begin
               q <= d;
            end
         end
      end else begin : g_wire
         logic unused_ctl;
         assign unused_ctl = clk ^ rst ^ en;
         assign q = d;
      end
   endgenerate

endmodule

// File: rtl/adder_tree_packer.sv
// Packs a stream of DATAWIDTH samples into NUM_INPUTS-lane vectors for an
// adder tree.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   s_valid / s_ready / s_data / s_last : sample stream in
//   o_valid / o_ready / o_data / o_lanes : packed vector out
// Build option: define ADDER_TREE_PACKER_PAD_EN to let s_last close a frame
// early with the remaining lanes zero; otherwise s_last is ignored.
//
// state | meaning
// FILL  | collecting samples into the fill buffer, s_ready = 1
// STALL | full frame waiting for the occupied output register, s_ready = 0
module adder_tree_packer
   import adder_tree_pkg::*;
#(
   parameter int DATAWIDTH   = 4,
   parameter int NUM_INPUTS  = 16,
   parameter int INSTANCE_ID = 0
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       s_valid,
   output logic                                       s_ready,
   input  logic [DATAWIDTH-1:0]                       s_data,
   input  logic                                       s_last,
   output logic                                       o_valid,
   input  logic                                       o_ready,
   output logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]       o_data,
   output logic [$clog2(NUM_INPUTS+1)-1:0]            o_lanes
);

   localparam int LW  = lane_cnt_w(NUM_INPUTS);
   localparam int IW  = $clog2(NUM_INPUTS);
   localparam int VW  = NUM_INPUTS * DATAWIDTH;
   localparam int SW  = VW + LW + 1;
   localparam int unused_id = INSTANCE_ID;

   typedef logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] vec_t;

   packer_state_t state;
   logic [IW-1:0] idx;
   vec_t          fill_buf;
   vec_t          frame;
   logic [LW-1:0] pend_lanes;
   logic [LW-1:0] frame_lanes;
   logic          s_ready_r;
   logic          accept;
   logic          complete;
   logic          out_free;
   logic          load_fill;
   logic          load_stall;
   logic          stage_en;
   logic [SW-1:0] stage_d;
   logic [SW-1:0] stage_q;

   assign s_ready = s_ready_r;
   assign accept  = s_valid && s_ready_r;

   // Buffer contents with the current sample merged in at its lane.
   always_comb begin
      frame      = fill_buf;
      frame[idx] = s_data;
   end

   assign frame_lanes = LW'(idx) + LW'(1);

`ifdef ADDER_TREE_PACKER_PAD_EN
   assign complete = accept && ((idx == IW'(NUM_INPUTS - 1)) || s_last);
`else
   logic unused_last;
   assign unused_last = s_last;
   assign complete    = accept && (idx == IW'(NUM_INPUTS - 1));
`endif

   assign o_valid  = stage_q[SW-1];
   assign o_lanes  = stage_q[SW-2 -: LW];
   assign o_data   = stage_q[VW-1:0];
   assign out_free = !o_valid || o_ready;

   assign load_fill  = (state == FILL) && complete && out_free;
   assign load_stall = (state == STALL) && o_ready;

   // A consumed vector with nothing new behind it drops valid but keeps data.
   assign stage_en = load_fill || load_stall || o_ready;

   always_comb begin
      stage_d = {1'b0, stage_q[SW-2:0]};
      if (load_fill) begin
         stage_d = {1'b1, frame_lanes, frame};
      end else if (load_stall) begin
         stage_d = {1'b1, pend_lanes, fill_buf};
      end
   end

   pipeline_stage #(
      .WIDTH  (SW),
      .ENABLE (1)
   ) u_out_reg (
      .clk (clk),
      .rst (rst),
      .en  (stage_en),
      .d   (stage_d),
      .q   (stage_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= FILL;
         idx        <= '0;
         fill_buf   <= '0;
         pend_lanes <= '0;
         s_ready_r  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               s_ready_r <= 1'b1;
               if (complete) begin
                  idx <= '0;
                  if (out_free) begin
                     fill_buf <= '0;
                  end else begin
                     fill_buf   <= frame;
                     pend_lanes <= frame_lanes;
                     state      <= STALL;
                     s_ready_r  <= 1'b0;
                  end
               end else if (accept) begin
                  fill_buf <= frame;
                  idx      <= idx + IW'(1);
               end
            end
            STALL: begin
               if (o_ready) begin
                  fill_buf  <= '0;
                  state     <= FILL;
                  s_ready_r <= 1'b1;
               end
            end
            default: begin
               state     <= FILL;
               s_ready_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_tree_packer.sv
module tb_adder_tree_packer;

   localparam int DW = 4;
   localparam int NI = 4;

   logic                     clk;
   logic                     rst;
   logic                     s_valid;
   logic                     s_ready;
   logic [DW-1:0]            s_data;
   logic                     s_last;
   logic                     o_valid;
   logic                     o_ready;
   logic [NI-1:0][DW-1:0]    o_data;
   logic [$clog2(NI+1)-1:0]  o_lanes;

   int n_tests;
   int n_fail;

   adder_tree_packer #(
      .DATAWIDTH   (DW),
      .NUM_INPUTS  (NI),
      .INSTANCE_ID (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_lanes (o_lanes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample for exactly one edge.
   task automatic send(input logic [DW-1:0] d, input logic last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      logic [31:0] sum;
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      o_ready = 1'b1;

      // Reset values
      #12;
      check_eq("rst_s_ready", 32'(s_ready), 32'd0);
      check_eq("rst_o_valid", 32'(o_valid), 32'd0);
      check_eq("rst_o_data",  32'(o_data),  32'h0);
      check_eq("rst_o_lanes", 32'(o_lanes), 32'd0);
      #5 rst = 1'b1;            // released mid-cycle at t=17
      #4;
      check_eq("pre_edge_s_ready", 32'(s_ready), 32'd0);
      tick();
      check_eq("post_rst_s_ready", 32'(s_ready), 32'd1);

      // Single frame 1..4
      for (int i = 1; i <= 4; i++) begin
         send(DW'(i), 1'b0);
         if (i < 4) check_eq("single_no_valid_early", 32'(o_valid), 32'd0);
      end
      check_eq("single_o_valid", 32'(o_valid), 32'd1);
      check_eq("single_o_data",  32'(o_data),  32'h4321);
      check_eq("single_o_lanes", 32'(o_lanes), 32'd4);
      sum = 0;
      for (int l = 0; l < NI; l++) sum += 32'(o_data[l]);
      check_eq("tree_sum", sum, 32'd10);
      tick();
      check_eq("single_valid_drop", 32'(o_valid), 32'd0);

      // Back-to-back frames 1..4, 5..8
      for (int k = 0; k < 8; k++) begin
         check_eq("b2b_s_ready", 32'(s_ready), 32'd1);
         send(DW'(k + 1), 1'b0);
         check_eq("b2b_o_valid", 32'(o_valid), (k == 3 || k == 7) ? 32'd1 : 32'd0);
         if (k == 7) check_eq("b2b_o_data2", 32'(o_data), 32'h8765);
      end
      tick();
      check_eq("b2b_idle", 32'(o_valid), 32'd0);

      // Stall: second frame arrives while first is still held
      for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0);
      o_ready = 1'b0;
      for (int i = 5; i <= 8; i++) send(DW'(i), 1'b0);
      check_eq("stall_s_ready", 32'(s_ready), 32'd0);
      check_eq("stall_o_valid", 32'(o_valid), 32'd1);
      check_eq("stall_hold_data", 32'(o_data), 32'h4321);
      tick();
      tick();
      check_eq("stall_hold_data2", 32'(o_data), 32'h4321);
      check_eq("stall_hold_lanes", 32'(o_lanes), 32'd4);
      o_ready = 1'b1;
      tick();
      check_eq("unstall_o_data",  32'(o_data),  32'h8765);
      check_eq("unstall_o_valid", 32'(o_valid), 32'd1);
      check_eq("unstall_s_ready", 32'(s_ready), 32'd1);
      tick();
      check_eq("unstall_drop", 32'(o_valid), 32'd0);

      // Short frame with s_last
      send(4'd9, 1'b0);
      send(4'd10, 1'b1);
`ifdef ADDER_TREE_PACKER_PAD_EN
      check_eq("pad_o_valid", 32'(o_valid), 32'd1);
      check_eq("pad_o_data",  32'(o_data),  32'h00A9);
      check_eq("pad_o_lanes", 32'(o_lanes), 32'd2);
      tick();
`else
      check_eq("nopad_no_valid", 32'(o_valid), 32'd0);
      send(4'd11, 1'b0);
      check_eq("nopad_no_valid3", 32'(o_valid), 32'd0);
      send(4'd12, 1'b0);
      check_eq("nopad_o_valid", 32'(o_valid), 32'd1);
      check_eq("nopad_o_data",  32'(o_data),  32'hCBA9);
      check_eq("nopad_o_lanes", 32'(o_lanes), 32'd4);
      tick();
`endif

      // s_last on the final lane: same in both builds
      send(4'd1, 1'b0);
      send(4'd3, 1'b0);
      send(4'd5, 1'b0);
      send(4'd7, 1'b1);
      check_eq("last_full_o_valid", 32'(o_valid), 32'd1);
      check_eq("last_full_o_data",  32'(o_data),  32'h7531);
      check_eq("last_full_o_lanes", 32'(o_lanes), 32'd4);
      tick();

      // Reset mid-frame discards partial data
      send(4'd1, 1'b0);
      send(4'd2, 1'b0);
      #2 rst = 1'b0;
      #3;
      check_eq("midrst_o_valid", 32'(o_valid), 32'd0);
      check_eq("midrst_s_ready", 32'(s_ready), 32'd0);
      tick();
      #2 rst = 1'b1;
      tick();
      check_eq("midrst_o_valid2", 32'(o_valid), 32'd0);
      for (int i = 3; i <= 6; i++) begin
         send(DW'(i), 1'b0);
         if (i < 6) check_eq("midrst_no_early", 32'(o_valid), 32'd0);
      end
      check_eq("midrst_o_valid3", 32'(o_valid), 32'd1);
      check_eq("midrst_o_data",   32'(o_data),  32'h6543);
      check_eq("midrst_o_lanes",  32'(o_lanes), 32'd4);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
